// File: rtl/imem_port_arbiter.sv
// Instruction-memory port sequencer: shares one prgrom port between
// CPU fetch and the UART downloader, holding the PC across a download.
module imem_port_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_mode,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [ADDR_W:0]   ld_count,
   output logic              cpu_hold,
   output logic              pc_restart,
   output logic              mem_ena,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [DATA_W-1:0] mem_dina,
   input  logic [DATA_W-1:0] mem_douta
);

   typedef enum logic [2:0] {
      S_RUN,
      S_DRAIN,
      S_LOAD,
      S_FINISH,
      S_RESUME
   } state_e;

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic              fetch_valid_q;
   logic              ld_ack_q;
   logic              cpu_hold_q;
   logic              pc_restart_q;
   logic [ADDR_W:0]   ld_count_q;
   logic              rd_issue;
   logic              wr_issue;

   // A held request is ignored in its ack cycle so it writes exactly once.
   // Reset gates the port so a write pending at reset is abandoned.
   assign rd_issue = (state_q == S_RUN) && !load_mode && fetch_req && !reset;
   assign wr_issue = (state_q == S_LOAD) && ld_req && !ld_ack_q && !reset;

   assign mem_ena   = rd_issue | wr_issue;
   assign mem_wea   = wr_issue;
   assign mem_addra = wr_issue ? ld_addr : fetch_addr;
   assign mem_dina  = wr_issue ? ld_wdata : '0;

   assign fetch_valid = fetch_valid_q;
   assign fetch_data  = fetch_valid_q ? mem_douta : '0;
   assign ld_ack      = ld_ack_q;
   assign ld_count    = ld_count_q;
   assign cpu_hold    = cpu_hold_q;
   assign pc_restart  = pc_restart_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:    if (load_mode) state_d = S_DRAIN;
         S_DRAIN:  state_d = S_LOAD;
         S_LOAD: begin
            if (!load_mode) state_d = wr_issue ? S_FINISH : S_RESUME;
         end
         S_FINISH: state_d = S_RESUME;
         S_RESUME: state_d = S_RUN;
         default:  state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_RUN;
         fetch_valid_q <= 1'b0;
         ld_ack_q      <= 1'b0;
         cpu_hold_q    <= 1'b0;
         pc_restart_q  <= 1'b0;
         ld_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_valid_q <= rd_issue;
         ld_ack_q      <= wr_issue;
         cpu_hold_q    <= (state_d != S_RUN);
         pc_restart_q  <= (state_d == S_RESUME);
         if (state_q == S_DRAIN) begin
            ld_count_q <= '0;
         end else if (wr_issue && ld_count_q != CNT_MAX) begin
            ld_count_q <= ld_count_q + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter with a memory macro model
// and a word-level scoreboard of expected memory contents.
module tb_imem_port_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int N  = 1 << AW;

   logic          clock;
   logic          reset;
   logic          load_mode;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;
   logic          fetch_valid;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_ack;
   logic [AW:0]   ld_count;
   logic          cpu_hold;
   logic          pc_restart;
   logic          mem_ena;
   logic          mem_wea;
   logic [AW-1:0] mem_addra;
   logic [DW-1:0] mem_dina;
   logic [DW-1:0] mem_douta;

   imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_mode  (load_mode),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_data (fetch_data),
      .fetch_valid(fetch_valid),
      .ld_req     (ld_req),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_ack     (ld_ack),
      .ld_count   (ld_count),
      .cpu_hold   (cpu_hold),
      .pc_restart (pc_restart),
      .mem_ena    (mem_ena),
      .mem_wea    (mem_wea),
      .mem_addra  (mem_addra),
      .mem_dina   (mem_dina),
      .mem_douta  (mem_douta)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // prgrom macro: unwritten words read back as addr*4
   logic [DW-1:0] mem [N];
   bit            wr  [N];
   always_ff @(posedge clock) begin
      if (mem_ena) begin
         if (mem_wea) begin
            mem[mem_addra] <= mem_dina;
            wr[mem_addra]  <= 1'b1;
         end else begin
            mem_douta <= wr[mem_addra] ? mem[mem_addra] : (32'(mem_addra) << 2);
         end
      end
   end

   logic [DW-1:0] exp_mem [N];
   int            n_chk;
   int            n_err;
   int            wcount;
   logic          pv;
   logic [AW-1:0] pa;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [AW:0] cnt_exp(input int w);
      return (w > N) ? (AW+1)'(N) : (AW+1)'(w);
   endfunction

   task automatic chk_fetch();
      check("fvalid", 64'(fetch_valid), 64'(pv));
      if (pv) check("fdata", 64'(fetch_data), 64'(exp_mem[pa]));
   endtask

   task automatic rd(input logic req, input logic [AW-1:0] a);
      fetch_req  = req;
      fetch_addr = a;
      #2;
      check("rd_ena", 64'(mem_ena), 64'(req));
      check("rd_wea", 64'(mem_wea), 64'd0);
      if (req) check("rd_addr", 64'(mem_addra), 64'(a));
      check("rd_hold", 64'(cpu_hold), 64'd0);
      chk_fetch();
      pv = req;
      pa = a;
      tick();
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++)
         rd(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, N-1)));
   endtask

   task automatic enter_load();
      load_mode  = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = AW'($urandom_range(0, N-1));
      #2;
      check("lm_ena", 64'(mem_ena), 64'd0);
      check("lm_hold", 64'(cpu_hold), 64'd0);
      chk_fetch();
      pv = 1'b0;
      tick();
      #2;
      check("drain_hold", 64'(cpu_hold), 64'd1);
      check("drain_ena", 64'(mem_ena), 64'd0);
      check("drain_fvalid", 64'(fetch_valid), 64'd0);
      tick();
      ld_req = 1'b0;
      #2;
      check("load_ena", 64'(mem_ena), 64'd0);
      check("load_hold", 64'(cpu_hold), 64'd1);
      check("load_cnt0", 64'(ld_count), 64'd0);
      check("load_fvalid", 64'(fetch_valid), 64'd0);
      wcount = 0;
      tick();
   endtask

   // mode 0: stay in load; 1: drop load_mode with the write; 2: drop in ack cycle
   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int mode);
      ld_req    = 1'b1;
      ld_addr   = a;
      ld_wdata  = d;
      load_mode = (mode != 1);
      #2;
      check("wr_ena", 64'(mem_ena), 64'd1);
      check("wr_wea", 64'(mem_wea), 64'd1);
      check("wr_addr", 64'(mem_addra), 64'(a));
      check("wr_data", 64'(mem_dina), 64'(d));
      check("wr_noack", 64'(ld_ack), 64'd0);
      exp_mem[a] = d;
      wcount++;
      tick();
      if (mode == 1) ld_req = 1'b0;
      if (mode == 2) load_mode = 1'b0;
      #2;
      check("ack", 64'(ld_ack), 64'd1);
      check("ack_nodup", 64'(mem_ena), 64'd0);
      check("ack_cnt", 64'(ld_count), 64'(cnt_exp(wcount)));
      check("ack_hold", 64'(cpu_hold), 64'd1);
      check("ack_norst", 64'(pc_restart), 64'd0);
      tick();
      if (mode != 0) begin
         ld_req     = 1'b0;
         fetch_req  = 1'b1;
         fetch_addr = '0;
         #2;
         check("res_pcr", 64'(pc_restart), 64'd1);
         check("res_hold", 64'(cpu_hold), 64'd1);
         check("res_ack", 64'(ld_ack), 64'd0);
         check("res_ena", 64'(mem_ena), 64'd0);
         pv = 1'b0;
         tick();
         #2;
         check("run_pcr", 64'(pc_restart), 64'd0);
         check("run_cnt", 64'(ld_count), 64'(cnt_exp(wcount)));
         rd(1'b1, '0);
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      wcount = 0;
      pv = 1'b0;
      pa = '0;
      for (int i = 0; i < N; i++) exp_mem[i] = 32'(i * 4);
      reset = 1'b1;
      load_mode = 1'b0;
      fetch_req = 1'b0;
      fetch_addr = '0;
      ld_req = 1'b0;
      ld_addr = '0;
      ld_wdata = '0;
      tick();
      tick();
      reset = 1'b0;
      #2;
      check("rst_fvalid", 64'(fetch_valid), 64'd0);
      check("rst_fdata", 64'(fetch_data), 64'd0);
      check("rst_ack", 64'(ld_ack), 64'd0);
      check("rst_hold", 64'(cpu_hold), 64'd0);
      check("rst_pcr", 64'(pc_restart), 64'd0);
      check("rst_cnt", 64'(ld_count), 64'd0);
      check("rst_ena", 64'(mem_ena), 64'd0);
      tick();

      rd(1'b1, AW'(0));
      rd(1'b1, AW'(1));
      rd(1'b1, AW'(2));
      rand_reads(20);
      rd(1'b1, AW'($urandom_range(0, N-1)));

      enter_load();
      for (int i = 0; i < 3; i++)
         write_word(AW'(i), 32'hA5A5_0000 + 32'(i), 0);
      write_word(AW'(3), 32'($urandom()), 1);
      for (int i = 0; i < 4; i++) rd(1'b1, AW'(i));
      rand_reads(20);

      rd(1'b1, AW'(5));
      enter_load();
      write_word(AW'(7), 32'($urandom()), 0);
      ld_req = 1'b1;
      ld_addr = AW'(9);
      ld_wdata = 32'hDEAD_BEEF;
      reset = 1'b1;
      #2;
      check("rst_nowr", 64'(mem_ena), 64'd0);
      tick();
      reset = 1'b0;
      load_mode = 1'b0;
      ld_req = 1'b0;
      fetch_req = 1'b1;
      fetch_addr = AW'(9);
      #2;
      check("mrst_ack", 64'(ld_ack), 64'd0);
      check("mrst_hold", 64'(cpu_hold), 64'd0);
      check("mrst_cnt", 64'(ld_count), 64'd0);
      check("mrst_fvalid", 64'(fetch_valid), 64'd0);
      check("mrst_pcr", 64'(pc_restart), 64'd0);
      check("mrst_run", 64'(mem_ena), 64'd1);
      pv = 1'b1;
      pa = AW'(9);
      tick();
      rd(1'b1, AW'(7));
      rand_reads(10);

      rd(1'b0, '0);
      enter_load();
      for (int i = 0; i < N + 2; i++)
         write_word(AW'($urandom_range(0, N-1)), 32'($urandom()), 0);
      write_word(AW'($urandom_range(0, N-1)), 32'($urandom()), 2);
      for (int i = 0; i < N; i++) rd(1'b1, AW'(i));
      rand_reads(20);
      rd(1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
